// File: rtl/ifetch_buffer_pkg.sv
// Shared types and helpers for the instruction-fetch buffer.
package ifetch_buffer_pkg;

  // Default widths of the instruction-address path and the instruction word.
  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0]  iaddr_t;
  typedef logic [INSTR_W_DEF-1:0] iword_t;

  // One buffered fetch: the PC it was issued for, the returned word, and
  // whether the word has come back yet.
  typedef struct packed {
    iaddr_t pc;
    iword_t instr;
    logic   filled;
  } fetch_entry_t;

  // Ceiling log2, used for pointer widths (n >= 2).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ifetch_ring.sv
// Ring storage for in-order fetches: entries are allocated at issue, filled
// when the response returns and popped when decode takes the head.
module ifetch_ring
  import ifetch_buffer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               alloc,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               pop,
  output logic               head_filled,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  localparam int PW = clog2(DEPTH);

  // Entry fields are sized by the shared instruction-address path type, so
  // ADDR_W / INSTR_W are expected to stay at the package defaults.
  fetch_entry_t  ring_r [DEPTH];
  logic [PW-1:0] alloc_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [PW-1:0] head_ptr_r;

  // Entry storage and the three wrapping pointers; clear restarts the ring empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= '0;
      end
    end else if (clear) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        ring_r[alloc_ptr_r].pc     <= alloc_pc;
        ring_r[alloc_ptr_r].filled <= 1'b0;
        alloc_ptr_r                <= alloc_ptr_r + PW'(1);
      end
      if (fill) begin
        ring_r[fill_ptr_r].instr  <= fill_data;
        ring_r[fill_ptr_r].filled <= 1'b1;
        fill_ptr_r                <= fill_ptr_r + PW'(1);
      end
      if (pop) begin
        ring_r[head_ptr_r].filled <= 1'b0;
        head_ptr_r                <= head_ptr_r + PW'(1);
      end
    end
  end

  assign head_filled = ring_r[head_ptr_r].filled;
  assign head_pc     = ring_r[head_ptr_r].pc;
  assign head_instr  = ring_r[head_ptr_r].instr;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: issues in-order fetches from the current PC,
// buffers returned words with their PCs, hands them to decode, and discards
// wrong-path fetches on a jump redirect.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready
);

  localparam int         CW      = clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0]      count_r;   // allocated entries
  logic [CW-1:0]      pend_r;    // allocated entries still waiting for data
  logic [CW-1:0]      drop_r;    // wrong-path responses still to arrive
  logic               credit_ok_s;
  logic               accept_s;
  logic               fill_s;
  logic               pop_s;
  logic               head_filled_s;
  logic [ADDR_W-1:0]  head_pc_s;
  logic [INSTR_W-1:0] head_instr_s;

  // Credit uses registered state only, so a slot freed this cycle is not reused until next.
  assign credit_ok_s    = ({1'b0, count_r} + {1'b0, drop_r}) < DEPTH_W;
  assign imem_req_valid = !rst && !flush && credit_ok_s;
  assign imem_req_addr  = pc_addr;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept_s || (flush && !rst);

  // Responses are stale while older wrong-path fetches are outstanding or during a redirect.
  assign fill_s    = imem_rsp_valid && (drop_r == '0) && !flush;

  assign out_valid = !rst && head_filled_s && (count_r != '0) && !flush;
  assign pop_s     = out_valid && out_ready;
  assign out_pc    = (count_r != '0) ? head_pc_s : '0;
  assign out_instr = (count_r != '0) ? head_instr_s : '0;

  ifetch_ring #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (flush),
    .alloc       (accept_s),
    .alloc_pc    (pc_addr),
    .fill        (fill_s),
    .fill_data   (imem_rsp_data),
    .pop         (pop_s),
    .head_filled (head_filled_s),
    .head_pc     (head_pc_s),
    .head_instr  (head_instr_s)
  );

  // Occupancy, pending-data and stale-response counters; a redirect turns pending into stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      pend_r  <= '0;
      drop_r  <= '0;
    end else if (flush) begin
      count_r <= '0;
      pend_r  <= '0;
      // A response arriving now is itself stale, whichever group it belongs to.
      drop_r  <= drop_r + pend_r - CW'(imem_rsp_valid);
    end else begin
      count_r <= count_r + CW'(accept_s) - CW'(pop_s);
      pend_r  <= pend_r + CW'(accept_s) - CW'(fill_s);
      if (imem_rsp_valid && (drop_r != '0)) begin
        drop_r <= drop_r - CW'(1);
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  // A response needs an outstanding request behind it.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((pend_r + drop_r) != '0));

  // In-flight plus buffered work never exceeds the ring size.
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_r} + {1'b0, drop_r}) <= DEPTH_W);

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed vector table, hand-written async-reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_ifetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int total;
  int bad;

  ifetch_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_addr        (pc_addr),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctl = {flush, req_ready, rsp_valid, out_ready}
  // ex  = {req_valid, pc_advance, out_valid, check_instr}
  typedef struct {
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic [31:0] rd;
    logic [3:0]  ex;
    logic [31:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] pc, input logic [3:0] ctl, input logic [31:0] rd,
                     input logic [3:0] ex, input logic [31:0] epc, input logic [31:0] ein);
    vec_t v;
    v.pc = pc; v.ctl = ctl; v.rd = rd; v.ex = ex; v.epc = epc; v.ein = ein;
    vecs.push_back(v);
  endtask

  // Reference model: in-order queue of fetches plus a count of stale responses.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ment_t;

  ment_t mq[$];
  int    mdrop;

  initial begin
    logic        e_rqv, e_adv, e_ov;
    logic [31:0] e_pc, e_in;
    logic [31:0] pc_r;
    int          mem_out;
    int          unfilled;
    ment_t       ne;

    total = 0;
    bad = 0;
    rst = 1'b1;
    pc_addr = 32'h0;
    flush = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    @(posedge clk);
    #3;
    chk("rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst pc_advance", {31'h0, pc_advance}, 32'h0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // stream
    add(32'h0,   4'b0101, 32'h0,   4'b1101, 32'h0, 32'h0);
    add(32'h4,   4'b0111, 32'h13,  4'b1100, 32'h0, 32'h0);
    add(32'h8,   4'b0111, 32'h93,  4'b1111, 32'h0, 32'h13);
    add(32'hC,   4'b0011, 32'h113, 4'b1011, 32'h4, 32'h93);
    add(32'hC,   4'b0001, 32'h0,   4'b1011, 32'h8, 32'h113);
    add(32'hC,   4'b0001, 32'h0,   4'b1001, 32'h0, 32'h0);
    // back-pressure
    add(32'h10,  4'b0100, 32'h0,   4'b1101, 32'h0,  32'h0);
    add(32'h14,  4'b0110, 32'hA0,  4'b1100, 32'h10, 32'h0);
    add(32'h18,  4'b0110, 32'hA1,  4'b1111, 32'h10, 32'hA0);
    add(32'h1C,  4'b0110, 32'hA2,  4'b1111, 32'h10, 32'hA0);
    add(32'h20,  4'b0110, 32'hA3,  4'b0011, 32'h10, 32'hA0);
    add(32'h20,  4'b0100, 32'h0,   4'b0011, 32'h10, 32'hA0);
    add(32'h20,  4'b0101, 32'h0,   4'b0011, 32'h10, 32'hA0);
    add(32'h20,  4'b0100, 32'h0,   4'b1111, 32'h14, 32'hA1);
    add(32'h24,  4'b0011, 32'hA4,  4'b0011, 32'h14, 32'hA1);
    add(32'h24,  4'b0001, 32'h0,   4'b1011, 32'h18, 32'hA2);
    add(32'h24,  4'b0001, 32'h0,   4'b1011, 32'h1C, 32'hA3);
    add(32'h24,  4'b0001, 32'h0,   4'b1011, 32'h20, 32'hA4);
    add(32'h24,  4'b0001, 32'h0,   4'b1001, 32'h0,  32'h0);
    // memory stall
    add(32'h40,  4'b0001, 32'h0,   4'b1001, 32'h0,  32'h0);
    add(32'h40,  4'b0001, 32'h0,   4'b1001, 32'h0,  32'h0);
    add(32'h40,  4'b0001, 32'h0,   4'b1001, 32'h0,  32'h0);
    add(32'h40,  4'b0101, 32'h0,   4'b1101, 32'h0,  32'h0);
    add(32'h44,  4'b0111, 32'h55,  4'b1100, 32'h40, 32'h0);
    add(32'h48,  4'b0001, 32'h0,   4'b1011, 32'h40, 32'h55);
    add(32'h48,  4'b0011, 32'h66,  4'b1000, 32'h44, 32'h0);
    add(32'h48,  4'b0001, 32'h0,   4'b1011, 32'h44, 32'h66);
    // flush with two in flight
    add(32'h10,  4'b0101, 32'h0,   4'b1101, 32'h0,  32'h0);
    add(32'h14,  4'b0101, 32'h0,   4'b1100, 32'h10, 32'h0);
    add(32'h18,  4'b1101, 32'h0,   4'b0100, 32'h10, 32'h0);
    add(32'h100, 4'b0011, 32'hBAD1, 4'b1001, 32'h0, 32'h0);
    add(32'h100, 4'b0011, 32'hBAD2, 4'b1001, 32'h0, 32'h0);
    add(32'h100, 4'b0101, 32'h0,   4'b1101, 32'h0,  32'h0);
    add(32'h104, 4'b0011, 32'hDEADBEEF, 4'b1000, 32'h100, 32'h0);
    add(32'h104, 4'b0001, 32'h0,   4'b1011, 32'h100, 32'hDEADBEEF);
    // flush coinciding with a response and a pop
    add(32'h200, 4'b0100, 32'h0,   4'b1101, 32'h0,   32'h0);
    add(32'h204, 4'b0110, 32'h11,  4'b1100, 32'h200, 32'h0);
    add(32'h208, 4'b0100, 32'h0,   4'b1111, 32'h200, 32'h11);
    add(32'h20C, 4'b1111, 32'h22,  4'b0101, 32'h200, 32'h11);
    add(32'h300, 4'b0111, 32'h33,  4'b1101, 32'h0,   32'h0);
    add(32'h304, 4'b0011, 32'h44,  4'b1000, 32'h300, 32'h0);
    add(32'h304, 4'b0001, 32'h0,   4'b1011, 32'h300, 32'h44);
    add(32'h304, 4'b0001, 32'h0,   4'b1001, 32'h0,   32'h0);
    // fill to three entries before the async reset
    add(32'h400, 4'b0100, 32'h0,   4'b1101, 32'h0,   32'h0);
    add(32'h404, 4'b0110, 32'h77,  4'b1100, 32'h400, 32'h0);
    add(32'h408, 4'b0110, 32'h78,  4'b1111, 32'h400, 32'h77);

    foreach (vecs[i]) begin
      pc_addr        = vecs[i].pc;
      flush          = vecs[i].ctl[3];
      imem_req_ready = vecs[i].ctl[2];
      imem_rsp_valid = vecs[i].ctl[1];
      imem_rsp_data  = vecs[i].rd;
      out_ready      = vecs[i].ctl[0];
      #2;
      chk($sformatf("row%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, vecs[i].ex[3]});
      chk($sformatf("row%0d pc_advance", i), {31'h0, pc_advance}, {31'h0, vecs[i].ex[2]});
      chk($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ex[1]});
      chk($sformatf("row%0d out_pc", i), out_pc, vecs[i].epc);
      chk($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].pc);
      if (vecs[i].ex[0]) begin
        chk($sformatf("row%0d out_instr", i), out_instr, vecs[i].ein);
      end
      @(posedge clk);
      #1;
    end

    // ---------------- async reset mid-stream (count = 3) ----------------
    pc_addr = 32'h40C;
    flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("pre-rst out_valid", {31'h0, out_valid}, 32'h1);
    chk("pre-rst req_valid", {31'h0, imem_req_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async out_valid", {31'h0, out_valid}, 32'h0);
    chk("async req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("async out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("post-rst req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("post-rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("post-rst out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;

    // ---------------- randomized traffic vs reference model ----------------
    mq.delete();
    mdrop = 0;
    mem_out = 0;
    pc_r = 32'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush          = ($urandom_range(0, 15) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      imem_rsp_valid = (mem_out > 0) && ($urandom_range(0, 1) == 1);
      imem_rsp_data  = $urandom;
      pc_addr        = pc_r;

      e_rqv = !flush && ((mq.size() + mdrop) < DEPTH);
      e_adv = (e_rqv && imem_req_ready) || flush;
      e_ov  = !flush && (mq.size() > 0) && mq[0].filled;
      e_pc  = (mq.size() > 0) ? mq[0].pc : 32'h0;
      e_in  = (mq.size() > 0) ? mq[0].instr : 32'h0;

      #2;
      chk("rnd req_valid", {31'h0, imem_req_valid}, {31'h0, e_rqv});
      chk("rnd pc_advance", {31'h0, pc_advance}, {31'h0, e_adv});
      chk("rnd out_valid", {31'h0, out_valid}, {31'h0, e_ov});
      chk("rnd out_pc", out_pc, e_pc);
      if (e_ov || (mq.size() == 0)) begin
        chk("rnd out_instr", out_instr, e_in);
      end

      // Memory side follows the actual handshake it sees.
      mem_out = mem_out + ((imem_req_valid && imem_req_ready) ? 1 : 0) - (imem_rsp_valid ? 1 : 0);

      // Model update.
      if (flush) begin
        unfilled = 0;
        foreach (mq[k]) begin
          if (!mq[k].filled) unfilled++;
        end
        mdrop = mdrop + unfilled - (imem_rsp_valid ? 1 : 0);
        mq.delete();
        pc_r = $urandom & 32'hFFFF_FFFC;
      end else begin
        if (e_ov && out_ready) begin
          void'(mq.pop_front());
        end
        if (imem_rsp_valid) begin
          if (mdrop > 0) begin
            mdrop--;
          end else begin
            for (int k = 0; k < mq.size(); k++) begin
              if (!mq[k].filled) begin
                mq[k].instr = imem_rsp_data;
                mq[k].filled = 1'b1;
                break;
              end
            end
          end
        end
        if (e_rqv && imem_req_ready) begin
          ne.pc = pc_r;
          ne.instr = 32'h0;
          ne.filled = 1'b0;
          mq.push_back(ne);
          pc_r = pc_r + 32'd4;
        end
      end

      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
